// File: rtl/dm_dmi_arbiter.sv
// ---------------------------------------------------------------------------
// dm_dmi_arbiter
//
// Round-robin arbiter that lets several debug transport modules share the
// single DMI slave port of the debug module CSR block. Exactly one request
// is accepted at a time. It is forwarded downstream from a register, and the
// downstream response is routed back to the port that issued the request.
// At most one DMI transaction is in flight.
//
// Flattened DMI payload layouts:
//   request  (ReqW  = 41): {addr[6:0], op[1:0], data[31:0]}
//   response (RespW = 34): {data[31:0], resp[1:0]}
// Port p's request occupies port_req_i[p*ReqW +: ReqW].
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   port_req_valid_i      per-port request valid
//   port_req_ready_o      per-port request accepted (only in IDLE)
//   port_req_i            per-port request payloads, packed
//   port_resp_valid_o     per-port response valid (owner only)
//   port_resp_ready_i     per-port response ready
//   port_resp_o           response payload shared by all ports
//   dmi_req_valid_o/ready_i, dmi_req_o       downstream request channel
//   dmi_resp_valid_i/ready_o, dmi_resp_i     downstream response channel
//   busy_o                high whenever a transaction is in progress
//   owner_o               index of the current or last granted port
// ---------------------------------------------------------------------------
module dm_dmi_arbiter #(
    parameter  int unsigned NrPorts = 2,
    localparam int unsigned ReqW    = 41,
    localparam int unsigned RespW   = 34,
    localparam int unsigned OwnerW  = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NrPorts-1:0]      port_req_valid_i,
    output logic [NrPorts-1:0]      port_req_ready_o,
    input  logic [NrPorts*ReqW-1:0] port_req_i,
    output logic [NrPorts-1:0]      port_resp_valid_o,
    input  logic [NrPorts-1:0]      port_resp_ready_i,
    output logic [RespW-1:0]        port_resp_o,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    output logic [ReqW-1:0]         dmi_req_o,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o,
    input  logic [RespW-1:0]        dmi_resp_i,
    output logic                    busy_o,
    output logic [OwnerW-1:0]       owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [OwnerW-1:0] r_prio;
    logic [OwnerW-1:0] r_owner;
    logic [ReqW-1:0]   r_req;

    logic              w_any;
    logic [OwnerW-1:0] w_winner;
    logic [ReqW-1:0]   w_req_sel;
    logic [OwnerW-1:0] w_prio_next;
    logic              w_owner_resp_ready;
    logic              w_resp_hs;
    int unsigned       w_dist;
    int unsigned       w_best_dist;

    // Round-robin pick: the winner is the valid port with the smallest
    // distance (j - prio) mod NrPorts. Computing distances instead of
    // rotating the request vector keeps every index a loop constant.
    always_comb begin
        w_any       = |port_req_valid_i;
        w_winner    = '0;
        w_req_sel   = '0;
        w_dist      = 0;
        w_best_dist = NrPorts;
        for (int unsigned j = 0; j < NrPorts; j++) begin
            if (port_req_valid_i[j]) begin
                w_dist = (j >= 32'(r_prio)) ? (j - 32'(r_prio))
                                            : (j + NrPorts - 32'(r_prio));
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_winner    = OwnerW'(j);
                    w_req_sel   = port_req_i[j*ReqW +: ReqW];
                end
            end
        end
    end

    always_comb begin
        w_owner_resp_ready = 1'b0;
        for (int unsigned j = 0; j < NrPorts; j++) begin
            if (OwnerW'(j) == r_owner) begin
                w_owner_resp_ready = port_resp_ready_i[j];
            end
        end
    end

    // Priority after a completed transaction: the port after the owner.
    assign w_prio_next = (r_owner == OwnerW'(NrPorts - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_next      = r_state;
        port_req_ready_o  = '0;
        port_resp_valid_o = '0;
        dmi_req_valid_o   = 1'b0;
        dmi_resp_ready_o  = 1'b0;
        w_resp_hs         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    for (int unsigned j = 0; j < NrPorts; j++) begin
                        port_req_ready_o[j] = (OwnerW'(j) == w_winner);
                    end
                    w_state_next = REQ;
                end
            end
            REQ: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                for (int unsigned j = 0; j < NrPorts; j++) begin
                    port_resp_valid_o[j] = dmi_resp_valid_i && (OwnerW'(j) == r_owner);
                end
                dmi_resp_ready_o = w_owner_resp_ready;
                if (dmi_resp_valid_i && w_owner_resp_ready) begin
                    w_resp_hs    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_prio  <= '0;
            r_owner <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any) begin
                r_req   <= w_req_sel;
                r_owner <= w_winner;
            end
            if (w_resp_hs) begin
                r_prio <= w_prio_next;
            end
        end
    end

    assign dmi_req_o   = r_req;
    assign port_resp_o = dmi_resp_i;
    assign busy_o      = (r_state != IDLE);
    assign owner_o     = r_owner;

endmodule

// File: tb/tb_dm_dmi_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for dm_dmi_arbiter with three upstream ports. Stimulus runs
// right after each rising edge; outputs are sampled 1 time unit later.
// The reference model is a round-robin pick over the valid mask using a
// priority integer that advances past the owner on each completed response.
// ---------------------------------------------------------------------------
module tb_dm_dmi_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [2:0]    port_req_valid_i;
    logic [2:0]    port_req_ready_o;
    logic [122:0]  port_req_i;
    logic [2:0]    port_resp_valid_o;
    logic [2:0]    port_resp_ready_i;
    logic [33:0]   port_resp_o;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    logic [40:0]   dmi_req_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    logic [33:0]   dmi_resp_i;
    logic          busy_o;
    logic [1:0]    owner_o;

    int n_checks = 0;
    int n_errors = 0;
    int m_prio   = 0;

    always #5 clk = ~clk;

    dm_dmi_arbiter #(.NrPorts(3)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .port_req_valid_i  (port_req_valid_i),
        .port_req_ready_o  (port_req_ready_o),
        .port_req_i        (port_req_i),
        .port_resp_valid_o (port_resp_valid_o),
        .port_resp_ready_i (port_resp_ready_i),
        .port_resp_o       (port_resp_o),
        .dmi_req_valid_o   (dmi_req_valid_o),
        .dmi_req_ready_i   (dmi_req_ready_i),
        .dmi_req_o         (dmi_req_o),
        .dmi_resp_valid_i  (dmi_resp_valid_i),
        .dmi_resp_ready_o  (dmi_resp_ready_o),
        .dmi_resp_i        (dmi_resp_i),
        .busy_o            (busy_o),
        .owner_o           (owner_o)
    );

    // Reference: first valid port found searching upward from prio, wrapping.
    function automatic int rr_pick(input logic [2:0] v, input int prio);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (prio + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [122:0] rand_payloads();
        logic [122:0] p;
        for (int i = 0; i < 4; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic drive_idle();
        port_req_valid_i  = '0;
        port_req_i        = '0;
        port_resp_ready_i = '0;
        dmi_req_ready_i   = 1'b0;
        dmi_resp_valid_i  = 1'b0;
        dmi_resp_i        = '0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst_i  = 1'b0;
        m_prio = 0;
    endtask

    // Drives one full transaction starting from IDLE and reports what was
    // observed; `bad` counts cycles where any output disagreed with the
    // protocol expected for that phase.
    task automatic run_txn(input logic [2:0] vmask, input logic [122:0] pl,
                           input int req_stall, input int resp_gap,
                           input int resp_stall, input logic [33:0] resp,
                           output int owner, output int bad,
                           output logic [40:0] req_seen,
                           output logic [2:0] rv_seen);
        int          exp_w;
        int          total;
        logic [40:0] exp_pl;
        logic [2:0]  onehot;
        logic        vld;
        logic        last;
        bad      = 0;
        req_seen = '0;
        rv_seen  = '0;
        exp_w    = rr_pick(vmask, m_prio);
        exp_pl   = pl[exp_w*41 +: 41];
        onehot   = 3'b001 << exp_w;

        port_req_valid_i  = vmask;
        port_req_i        = pl;
        dmi_req_ready_i   = 1'b0;
        dmi_resp_valid_i  = 1'b0;
        port_resp_ready_i = '0;
        #1;
        case (port_req_ready_o)
            3'b001:  owner = 0;
            3'b010:  owner = 1;
            3'b100:  owner = 2;
            default: owner = -1;
        endcase
        if (busy_o !== 1'b0) bad++;
        @(posedge clk); #1;
        port_req_i = ~pl;

        for (int k = 0; k <= req_stall; k++) begin
            dmi_req_ready_i   = (k == req_stall);
            dmi_resp_valid_i  = 1'b1;
            dmi_resp_i        = {$urandom, 2'($urandom)};
            port_resp_ready_i = 3'b111;
            #1;
            if (k == 0) req_seen = dmi_req_o;
            if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== exp_pl ||
                port_req_ready_o !== 3'b000 || port_resp_valid_o !== 3'b000 ||
                dmi_resp_ready_o !== 1'b0 || busy_o !== 1'b1 ||
                owner_o !== 2'(exp_w)) bad++;
            @(posedge clk); #1;
        end
        dmi_req_ready_i = 1'b0;

        total = resp_gap + resp_stall + 1;
        for (int k = 0; k < total; k++) begin
            vld  = (k >= resp_gap);
            last = (k == total - 1);
            dmi_resp_valid_i  = vld;
            dmi_resp_i        = resp;
            port_resp_ready_i = last ? 3'b111 : ~onehot;
            #1;
            rv_seen = port_resp_valid_o;
            if (port_resp_valid_o !== (vld ? onehot : 3'b000) ||
                port_resp_o !== resp || dmi_resp_ready_o !== last ||
                dmi_req_valid_o !== 1'b0 || port_req_ready_o !== 3'b000 ||
                busy_o !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        dmi_resp_valid_i  = 1'b0;
        port_resp_ready_i = '0;
        port_req_valid_i  = '0;
        #1;
        if (busy_o !== 1'b0) bad++;
        m_prio = (exp_w + 1) % N;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_idle();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (port_req_ready_o !== 3'b000) begin n_errors++; $display("FAIL reset_req_ready got %b expected 000", port_req_ready_o); end
        n_checks++; if (port_resp_valid_o !== 3'b000) begin n_errors++; $display("FAIL reset_resp_valid got %b expected 000", port_resp_valid_o); end
        n_checks++; if (dmi_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_dmi_req_valid got %b expected 0", dmi_req_valid_o); end
        n_checks++; if (dmi_resp_ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_dmi_resp_ready got %b expected 0", dmi_resp_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
        n_checks++; if (dmi_req_o !== 41'h0) begin n_errors++; $display("FAIL reset_dmi_req got %h expected 0", dmi_req_o); end
        n_checks++; if (owner_o !== 2'd0) begin n_errors++; $display("FAIL reset_owner got %0d expected 0", owner_o); end
        rst_i  = 1'b0;
        m_prio = 0;
    endtask

    task automatic test_single_write();
        logic [122:0] pl;
        logic [40:0]  exp_pl;
        logic [40:0]  req_seen;
        logic [2:0]   rv;
        int           owner;
        int           bad;
        apply_reset();
        exp_pl = {7'h10, 2'd2, 32'hDEADBEEF};
        pl     = {82'h0, exp_pl};
        run_txn(3'b001, pl, 0, 0, 0, 34'h0, owner, bad, req_seen, rv);
        n_checks++; if (owner !== 0) begin n_errors++; $display("FAIL single_owner got %0d expected 0", owner); end
        n_checks++; if (req_seen !== exp_pl) begin n_errors++; $display("FAIL single_payload got %h expected %h", req_seen, exp_pl); end
        n_checks++; if (rv !== 3'b001) begin n_errors++; $display("FAIL single_resp_route got %b expected 001", rv); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL single_protocol got %0d bad cycles expected 0", bad); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL single_busy_after got %b expected 0", busy_o); end
    endtask

    task automatic test_two_ports();
        logic [40:0] req_seen;
        logic [2:0]  rv;
        int          owner;
        int          bad;
        int          exp_w;
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            exp_w = rr_pick(3'b011, m_prio);
            run_txn(3'b011, rand_payloads(), $urandom_range(0, 2), 0,
                    $urandom_range(0, 2), {$urandom, 2'($urandom)},
                    owner, bad, req_seen, rv);
            n_checks++; if (owner !== exp_w) begin n_errors++; $display("FAIL two_ports_grant[%0d] got %0d expected %0d", t, owner, exp_w); end
            n_checks++; if (rv !== (3'b001 << exp_w)) begin n_errors++; $display("FAIL two_ports_route[%0d] got %b expected %b", t, rv, 3'b001 << exp_w); end
            n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL two_ports_protocol[%0d] got %0d bad cycles expected 0", t, bad); end
        end
    endtask

    task automatic test_backpressure();
        logic [40:0] req_seen;
        logic [2:0]  rv;
        int          owner;
        int          bad;
        int          exp_w;
        exp_w = rr_pick(3'b110, m_prio);
        run_txn(3'b110, rand_payloads(), 5, 0, 3, {$urandom, 2'b11},
                owner, bad, req_seen, rv);
        n_checks++; if (owner !== exp_w) begin n_errors++; $display("FAIL backpressure_grant got %0d expected %0d", owner, exp_w); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL backpressure_protocol got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_fairness();
        logic [40:0] req_seen;
        logic [2:0]  rv;
        int          owner;
        int          bad;
        apply_reset();
        for (int t = 0; t < 9; t++) begin
            run_txn(3'b111, rand_payloads(), $urandom_range(0, 1), 0,
                    $urandom_range(0, 1), {$urandom, 2'($urandom)},
                    owner, bad, req_seen, rv);
            n_checks++; if (owner !== t % N) begin n_errors++; $display("FAIL fairness_grant[%0d] got %0d expected %0d", t, owner, t % N); end
            n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL fairness_protocol[%0d] got %0d bad cycles expected 0", t, bad); end
        end
    endtask

    task automatic test_reset_mid();
        logic [40:0] req_seen;
        logic [2:0]  rv;
        int          owner;
        int          bad;
        int          exp_w;
        // Advance priority away from 0 so a non-cleared prio would show.
        run_txn(3'b010, rand_payloads(), 0, 0, 0, 34'h1, owner, bad, req_seen, rv);
        port_req_valid_i = 3'b001;
        port_req_i       = rand_payloads();
        @(posedge clk); #1;
        port_req_valid_i = '0;
        dmi_req_ready_i  = 1'b1;
        @(posedge clk); #1;
        dmi_req_ready_i   = 1'b0;
        dmi_resp_valid_i  = 1'b1;
        dmi_resp_i        = {$urandom, 2'($urandom)};
        port_resp_ready_i = 3'b000;
        #1;
        n_checks++; if (port_resp_valid_o !== 3'b001) begin n_errors++; $display("FAIL rstmid_pending got %b expected 001", port_resp_valid_o); end
        rst_i             = 1'b1;
        port_resp_ready_i = 3'b111;
        @(posedge clk); #1;
        n_checks++; if (port_resp_valid_o !== 3'b000 || dmi_resp_ready_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_resp got valid %b ready %b expected 000 0", port_resp_valid_o, dmi_resp_ready_o); end
        n_checks++; if (busy_o !== 1'b0 || dmi_req_valid_o !== 1'b0 || port_req_ready_o !== 3'b000) begin n_errors++; $display("FAIL rstmid_ctrl got busy %b reqv %b rdy %b expected 0 0 000", busy_o, dmi_req_valid_o, port_req_ready_o); end
        n_checks++; if (dmi_req_o !== 41'h0 || owner_o !== 2'd0) begin n_errors++; $display("FAIL rstmid_regs got req %h owner %0d expected 0 0", dmi_req_o, owner_o); end
        rst_i = 1'b0;
        drive_idle();
        m_prio = 0;
        exp_w = rr_pick(3'b110, m_prio);
        run_txn(3'b110, rand_payloads(), 0, 0, 0, 34'h2, owner, bad, req_seen, rv);
        n_checks++; if (owner !== exp_w) begin n_errors++; $display("FAIL rstmid_prio got %0d expected %0d", owner, exp_w); end
        run_txn(3'b100, rand_payloads(), 1, 1, 1, 34'h3, owner, bad, req_seen, rv);
        n_checks++; if (owner !== 2) begin n_errors++; $display("FAIL rstmid_port2 got %0d expected 2", owner); end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rstmid_protocol got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_spurious();
        logic [40:0] req_seen;
        logic [2:0]  rv;
        int          owner;
        int          bad;
        int          idle_bad;
        idle_bad = 0;
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            dmi_resp_valid_i  = 1'b1;
            dmi_resp_i        = {$urandom, 2'($urandom)};
            port_resp_ready_i = 3'b111;
            #1;
            if (dmi_resp_ready_o !== 1'b0 || port_resp_valid_o !== 3'b000 || busy_o !== 1'b0) idle_bad++;
            @(posedge clk); #1;
        end
        n_checks++; if (idle_bad !== 0) begin n_errors++; $display("FAIL spurious_idle got %0d bad cycles expected 0", idle_bad); end
        drive_idle();
        run_txn(3'b101, rand_payloads(), 4, 2, 0, {$urandom, 2'($urandom)}, owner, bad, req_seen, rv);
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL spurious_req got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_random();
        logic [40:0] req_seen;
        logic [2:0]  rv;
        logic [2:0]  vmask;
        int          owner;
        int          bad;
        int          exp_w;
        for (int t = 0; t < 20; t++) begin
            vmask = 3'($urandom_range(1, 7));
            exp_w = rr_pick(vmask, m_prio);
            run_txn(vmask, rand_payloads(), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), {$urandom, 2'($urandom)},
                    owner, bad, req_seen, rv);
            n_checks++; if (owner !== exp_w) begin n_errors++; $display("FAIL random_grant[%0d] mask %b got %0d expected %0d", t, vmask, owner, exp_w); end
            n_checks++; if (rv !== (3'b001 << exp_w)) begin n_errors++; $display("FAIL random_route[%0d] got %b expected %b", t, rv, 3'b001 << exp_w); end
            n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL random_protocol[%0d] got %0d bad cycles expected 0", t, bad); end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();
        test_reset();
        test_single_write();
        test_two_ports();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
